// File: rtl/apb_mem_bridge.sv
// APB completer bridging APB transfers onto the mem request interface.
// A narrow APB word is mapped onto one lane of the wide mem word. Hung accesses time out with PSLVERR.
module apb_mem_bridge #(
   parameter int APB_ADDR_WIDTH = 16,
   parameter int APB_DATA_WIDTH = 32,
   parameter int MEM_ADDR_WIDTH = 32,
   parameter int MEM_DATA_WIDTH = 128,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                          clk_i,
   input  logic                          reset_n_i,
   output logic [31:0]                   apb_mem_error_o,
   input  logic [APB_ADDR_WIDTH-1:0]     apb_paddr_i,
   input  logic [APB_DATA_WIDTH-1:0]     apb_pwdata_i,
   input  logic                          apb_pwrite_i,
   input  logic [APB_DATA_WIDTH/8-1:0]   apb_pstrb_i,
   input  logic                          apb_psel_i,
   input  logic                          apb_penable_i,
   output logic                          apb_pready_o,
   output logic [APB_DATA_WIDTH-1:0]     apb_prdata_o,
   output logic                          apb_pslverr_o,
   output logic                          mem_en_o,
   output logic                          mem_rreq_o,
   output logic [MEM_ADDR_WIDTH-1:0]     mem_addr_o,
   output logic [MEM_DATA_WIDTH/8-1:0]   mem_wben_o,
   output logic [MEM_DATA_WIDTH-1:0]     mem_wdata_o,
   input  logic [MEM_DATA_WIDTH-1:0]     mem_rdata_i,
   input  logic                          mem_rdata_avail_i,
   input  logic                          mem_stall_i
);

   localparam int APB_BYTES = APB_DATA_WIDTH / 8;
   localparam int MEM_BYTES = MEM_DATA_WIDTH / 8;
   localparam int NUM_LANES = MEM_DATA_WIDTH / APB_DATA_WIDTH;
   localparam int LANE_BITS = $clog2(NUM_LANES);
   localparam int LANE_W    = (LANE_BITS == 0) ? 1 : LANE_BITS;
   localparam int LANE_LSB  = $clog2(APB_BYTES);
   localparam int CNT_W     = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_RWAIT = 2'd2,
      S_RESP  = 2'd3
   } state_e;

   state_e                      state_q, state_d;
   logic [APB_ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [APB_DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [MEM_BYTES-1:0]        wben_q, wben_d;
   logic                        write_q, write_d;
   logic [LANE_W-1:0]           lane_q, lane_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic [APB_DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                        err_q, err_d;
   logic [31:0]                 err_cnt_q, err_cnt_d;

   logic [LANE_W-1:0]           lane_in;
   logic                        timeout_hit;
   logic                        busy;

   generate
      if (LANE_BITS == 0) begin : g_single_lane
         assign lane_in = '0;
      end else begin : g_multi_lane
         assign lane_in = apb_paddr_i[LANE_LSB +: LANE_BITS];
      end
   endgenerate

   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_VAL);
   assign busy        = (state_q != S_IDLE);

   // Every output decodes registered state only; IDLE forces the mem side to zero.
   assign mem_en_o        = (state_q == S_REQ) && !timeout_hit;
   assign mem_rreq_o      = mem_en_o && !write_q;
   assign mem_addr_o      = busy ? MEM_ADDR_WIDTH'(addr_q) : '0;
   assign mem_wben_o      = busy ? wben_q : '0;
   assign mem_wdata_o     = busy ? {NUM_LANES{wdata_q}} : '0;
   assign apb_pready_o    = (state_q == S_RESP);
   assign apb_prdata_o    = apb_pready_o ? rdata_q : '0;
   assign apb_pslverr_o   = apb_pready_o && err_q;
   assign apb_mem_error_o = err_cnt_q;

   always_comb begin
      // NOTE: every variable gets its hold value first so no path through the case infers a latch.
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wben_d    = wben_q;
      write_d   = write_q;
      lane_d    = lane_q;
      cnt_d     = cnt_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      err_cnt_d = err_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (apb_psel_i && !apb_penable_i) begin
               addr_d  = apb_paddr_i;
               wdata_d = apb_pwdata_i;
               write_d = apb_pwrite_i;
               lane_d  = lane_in;
               wben_d  = apb_pwrite_i ? (MEM_BYTES'(apb_pstrb_i) << (lane_in * APB_BYTES)) : '0;
               cnt_d   = '0;
               rdata_d = '0;
               err_d   = 1'b0;
               state_d = (apb_pwrite_i && (apb_pstrb_i == '0)) ? S_RESP : S_REQ;
            end
         end
         S_REQ: begin
            if (timeout_hit) begin
               state_d   = S_RESP;
               err_d     = 1'b1;
               rdata_d   = '0;
               err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 32'd1;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (!mem_stall_i) state_d = write_q ? S_RESP : S_RWAIT;
            end
         end
         S_RWAIT: begin
            // Returning data takes priority over a timeout landing in the same cycle.
            if (mem_rdata_avail_i) begin
               rdata_d = mem_rdata_i[lane_q * APB_DATA_WIDTH +: APB_DATA_WIDTH];
               state_d = S_RESP;
            end else if (timeout_hit) begin
               state_d   = S_RESP;
               err_d     = 1'b1;
               rdata_d   = '0;
               err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 32'd1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RESP: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         wben_q    <= '0;
         write_q   <= 1'b0;
         lane_q    <= '0;
         cnt_q     <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         // NOTE: non-blocking updates keep every flop sampling pre-edge values regardless of statement order.
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wben_q    <= wben_d;
         write_q   <= write_d;
         lane_q    <= lane_d;
         cnt_q     <= cnt_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

endmodule

// File: tb/tb_apb_mem_bridge.sv
// Scoreboard bench for apb_mem_bridge: stimulus queues expected APB responses, a monitor checks them.
// u_dut uses the default timeout; u_dut_to uses a 4-cycle timeout for the timeout scenarios.
module tb_apb_mem_bridge;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [15:0]   paddr;
   logic [31:0]   pwdata;
   logic          pwrite;
   logic [3:0]    pstrb;
   logic          psel_a, psel_b;
   logic          penable;
   logic [127:0]  mem_rdata;
   logic          mem_avail;
   logic          mem_stall;

   logic [31:0]   err_a, err_b;
   logic          pready_a, pready_b;
   logic [31:0]   prdata_a, prdata_b;
   logic          slverr_a, slverr_b;
   logic          mem_en_a, mem_en_b;
   logic          rreq_a, rreq_b;
   logic [31:0]   maddr_a, maddr_b;
   logic [15:0]   wben_a, wben_b;
   logic [127:0]  wdata_a, wdata_b;

   int            cyc = 0;
   int            n_checks = 0;
   int            n_err = 0;
   int            t0;

   typedef struct {
      string       name;
      logic [31:0] prdata;
      logic        slverr;
      int          t;
   } exp_t;
   exp_t scb[$];

   localparam logic [127:0] RDATA_PAT = {32'hAAAAAAAA, 32'h12345678, 32'hBBBBBBBB, 32'hCCCCCCCC};

   apb_mem_bridge u_dut (
      .clk_i(clk), .reset_n_i(rst_n), .apb_mem_error_o(err_a),
      .apb_paddr_i(paddr), .apb_pwdata_i(pwdata), .apb_pwrite_i(pwrite), .apb_pstrb_i(pstrb),
      .apb_psel_i(psel_a), .apb_penable_i(penable),
      .apb_pready_o(pready_a), .apb_prdata_o(prdata_a), .apb_pslverr_o(slverr_a),
      .mem_en_o(mem_en_a), .mem_rreq_o(rreq_a), .mem_addr_o(maddr_a), .mem_wben_o(wben_a),
      .mem_wdata_o(wdata_a), .mem_rdata_i(mem_rdata), .mem_rdata_avail_i(mem_avail),
      .mem_stall_i(mem_stall)
   );

   apb_mem_bridge #(.TIMEOUT_CYCLES(4)) u_dut_to (
      .clk_i(clk), .reset_n_i(rst_n), .apb_mem_error_o(err_b),
      .apb_paddr_i(paddr), .apb_pwdata_i(pwdata), .apb_pwrite_i(pwrite), .apb_pstrb_i(pstrb),
      .apb_psel_i(psel_b), .apb_penable_i(penable),
      .apb_pready_o(pready_b), .apb_prdata_o(prdata_b), .apb_pslverr_o(slverr_b),
      .mem_en_o(mem_en_b), .mem_rreq_o(rreq_b), .mem_addr_o(maddr_b), .mem_wben_o(wben_b),
      .mem_wdata_o(wdata_b), .mem_rdata_i(mem_rdata), .mem_rdata_avail_i(mem_avail),
      .mem_stall_i(mem_stall)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string name, input logic [31:0] rd, input logic se, input int t);
      exp_t e;
      e.name = name; e.prdata = rd; e.slverr = se; e.t = t;
      scb.push_back(e);
   endtask

   task automatic setup(input logic sel_b, input logic [15:0] a, input logic wr,
                        input logic [31:0] wd, input logic [3:0] st);
      psel_a  = !sel_b;
      psel_b  = sel_b;
      penable = 1'b0;
      paddr   = a;
      pwrite  = wr;
      pwdata  = wd;
      pstrb   = st;
   endtask

   task automatic idle_bus();
      psel_a  = 1'b0;
      psel_b  = 1'b0;
      penable = 1'b0;
   endtask

   // Monitor: every pready pulse must match the oldest queued response, including its cycle.
   always @(negedge clk) begin
      if (rst_n && (pready_a || pready_b)) begin
         if (scb.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_pready: got pready at cycle %0d, expected none", cyc);
         end else begin
            exp_t e;
            e = scb.pop_front();
            check({e.name, "_prdata"}, pready_a ? prdata_a : prdata_b, e.prdata);
            check({e.name, "_pslverr"}, pready_a ? slverr_a : slverr_b, e.slverr);
            check({e.name, "_cycle"}, cyc, e.t);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200000, expected finish earlier");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; mem_rdata = RDATA_PAT; mem_avail = 1'b0; mem_stall = 1'b0;
      paddr = '0; pwdata = '0; pwrite = 1'b0; pstrb = '0;
      idle_bus();
      tick(); tick();
      check("rst_pready", pready_a, 0);
      check("rst_mem_en", mem_en_a, 0);
      check("rst_wdata", wdata_a, 0);
      check("rst_err", err_b, 0);
      rst_n = 1'b1;
      tick();

      // 1: lane-1 write, no stall
      setup(1'b0, 16'h0014, 1'b1, 32'hDEADBEEF, 4'hF);
      t0 = cyc; push("t1_wr", 32'h0, 1'b0, t0 + 2);
      tick(); penable = 1'b1;
      check("t1_mem_en", mem_en_a, 1);
      check("t1_rreq", rreq_a, 0);
      check("t1_addr", maddr_a, 32'h14);
      check("t1_wben", wben_a, 16'h00F0);
      check("t1_wdata", wdata_a, {4{32'hDEADBEEF}});
      tick();
      tick(); idle_bus();
      check("t1_idle_wben", wben_a, 0);

      // 2: lane-2 read with 3 stall cycles, data 2 cycles after accept
      tick();
      setup(1'b0, 16'h0008, 1'b0, 32'h0, 4'h0); mem_stall = 1'b1;
      t0 = cyc; push("t2_rd", 32'h12345678, 1'b0, t0 + 7);
      tick(); penable = 1'b1;
      check("t2_mem_en", mem_en_a, 1);
      check("t2_rreq", rreq_a, 1);
      check("t2_addr", maddr_a, 32'h8);
      check("t2_wben", wben_a, 0);
      tick(); tick();
      tick(); mem_stall = 1'b0;
      tick();
      check("t2_rwait_en", mem_en_a, 0);
      tick(); mem_avail = 1'b1;
      tick(); mem_avail = 1'b0;
      tick(); idle_bus();

      // 3: write with empty strobes skips the mem side
      tick();
      setup(1'b0, 16'h0020, 1'b1, 32'hCAFEF00D, 4'h0);
      t0 = cyc; push("t3_nostrb", 32'h0, 1'b0, t0 + 1);
      tick(); penable = 1'b1;
      check("t3_mem_en", mem_en_a, 0);
      tick(); idle_bus();
      check("t3_mem_en_after", mem_en_a, 0);

      // 4: timeout with stall held high, then a late avail pulse
      tick();
      setup(1'b1, 16'h0004, 1'b0, 32'h0, 4'h0); mem_stall = 1'b1;
      t0 = cyc; push("t4_timeout", 32'h0, 1'b1, t0 + 6);
      tick(); penable = 1'b1;
      check("t4_en_t1", mem_en_b, 1);
      check("t4_rreq_t1", rreq_b, 1);
      tick(); tick(); tick();
      check("t4_en_t4", mem_en_b, 1);
      tick();
      check("t4_en_withdrawn", mem_en_b, 0);
      check("t4_rreq_withdrawn", rreq_b, 0);
      tick();
      tick(); idle_bus(); mem_stall = 1'b0; mem_avail = 1'b1;
      check("t4_err_count", err_b, 1);
      tick(); mem_avail = 1'b0;
      check("t4_late_en", mem_en_b, 0);
      check("t4_late_pready", pready_b, 0);
      check("t4_late_err", err_b, 1);

      // 4b: data arriving on the timeout cycle wins
      tick();
      setup(1'b1, 16'h000C, 1'b0, 32'h0, 4'h0);
      t0 = cyc; push("t4_datawins", 32'hAAAAAAAA, 1'b0, t0 + 6);
      tick(); penable = 1'b1;
      tick(); tick(); tick();
      tick(); mem_avail = 1'b1;
      tick(); mem_avail = 1'b0;
      tick(); idle_bus();
      check("t4b_err_count", err_b, 1);

      // 5: back-to-back write then read, reset during the read wait
      tick();
      setup(1'b0, 16'h0000, 1'b1, 32'h11223344, 4'h3);
      t0 = cyc; push("t5_wr", 32'h0, 1'b0, t0 + 2);
      tick(); penable = 1'b1;
      check("t5_wben", wben_a, 16'h0003);
      tick();
      tick(); setup(1'b0, 16'h0004, 1'b0, 32'h0, 4'h0);
      tick(); penable = 1'b1;
      check("t5_rd_en", mem_en_a, 1);
      check("t5_rd_rreq", rreq_a, 1);
      check("t5_rd_addr", maddr_a, 32'h4);
      tick();
      rst_n = 1'b0; idle_bus();
      #1;
      check("t5_rst_en", mem_en_a, 0);
      check("t5_rst_addr", maddr_a, 0);
      check("t5_rst_pready", pready_a, 0);
      check("t5_rst_err", err_b, 0);
      tick(); rst_n = 1'b1; mem_avail = 1'b1;
      tick(); mem_avail = 1'b0;
      check("t5_forgot_en", mem_en_a, 0);
      check("t5_forgot_pready", pready_a, 0);
      setup(1'b0, 16'h0004, 1'b0, 32'h0, 4'h0);
      t0 = cyc; push("t5_after_rst", 32'hBBBBBBBB, 1'b0, t0 + 3);
      tick(); penable = 1'b1;
      tick(); mem_avail = 1'b1;
      tick(); mem_avail = 1'b0;
      tick(); idle_bus();
      tick(); tick();
      check("scoreboard_drained", scb.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
